// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and iterative-ALU FSM encoding.
// The CPU decoder imports the same codes so both sides stay in step.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MULU = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Divide by zero short-circuits to a fixed answer instead of iterating.
    function automatic logic is_iterative(input logic [3:0] aluc, input logic divisor_zero);
        return (aluc == ALU_MULU) || ((aluc == ALU_DIVU) && !divisor_zero);
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU: valid/ready in, valid/ready out.
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;

    modport master (
        output in_valid, a, b, aluc, out_ready,
        input  in_ready, out_valid, result, hi, zero
    );

    modport slave (
        input  in_valid, a, b, aluc, out_ready,
        output in_ready, out_valid, result, hi, zero
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath; MULU, DIVU and unused codes yield zero here.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] y
);

    logic [SHW-1:0] shamt;

    // Shift amount comes from a, the shifted value from b.
    assign shamt = a[SHW-1:0];

    always_comb begin
        y = '0;
        case (aluc)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $unsigned($signed(b) >>> shamt);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ops finish in one cycle, MULU/DIVU take one
// bit per cycle (shift-add multiply, restoring divide) before presenting results.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       clrn,
    iter_alu_if.slave  bus
);

    alu_state_t       state;
    logic [3:0]       op;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] comb_y;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .a    (bus.a),
        .b    (bus.b),
        .aluc (bus.aluc),
        .y    (comb_y)
    );

    // One iteration step. acc_hi/acc_lo hold the partial product (multiplier
    // shifting out of acc_lo) or the partial remainder/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        step_hi   = '0;
        step_lo   = '0;
        if (op == ALU_MULU) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            op          <= ALU_ADD;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            count       <= '0;
            result_r    <= '0;
            hi_r        <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op         <= bus.aluc;
                        opnd       <= bus.b;
                        acc_lo     <= bus.a;
                        acc_hi     <= '0;
                        count      <= '0;
                        in_ready_r <= 1'b0;
                        if (is_iterative(bus.aluc, bus.b == '0)) begin
                            state <= ST_CALC;
                        end else begin
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                            if (bus.aluc == ALU_DIVU) begin
                                result_r <= '1;
                                hi_r     <= bus.a;
                            end else begin
                                result_r <= comb_y;
                                hi_r     <= '0;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == SHW'(WIDTH - 1)) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= step_lo;
                        hi_r        <= step_hi;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.hi        = hi_r;
    assign bus.zero      = (result_r == '0);

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: clrn  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: a  input  WIDTH  operand A (shift amount source for shifts).
REQ-008 Port: b  input  WIDTH  operand B (shifted value for shifts).
REQ-009 Port: aluc  input  4  operation code.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  consumer takes result.
REQ-012 Port: result  output  WIDTH  main result (low product, quotient).
REQ-013 Port: hi  output  WIDTH  high product / remainder; 0 for other ops.
REQ-014 Port: zero  output  1  result == 0.

Function
REQ-015 aluc codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT signed, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1100 MULU, 1101 DIVU; all others give result 0, hi 0.
REQ-016 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-017 SLT/SLTU: result = 1 if a < b (signed/unsigned), else 0.
REQ-018 Shifts: b shifted by a[SHW-1:0]; SRA replicates b[WIDTH-1].
REQ-019 FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-020 Request accepted on cycle where in_valid && in_ready; a, b, aluc captured then; inputs ignored afterwards.
REQ-021 Single-cycle ops (all except MULU/DIVU): IDLE -> DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-022 MULU: unsigned shift-add, one bit per cycle; IDLE -> CALC for exactly WIDTH cycles -> DONE; out_valid WIDTH+1 cycles after acceptance; {hi,result} = full 2*WIDTH product.
REQ-023 DIVU: unsigned restoring division, one bit per cycle, same timing as MULU; result = quotient, hi = remainder.
REQ-024 DIVU with b == 0: IDLE -> DONE directly (latency 1); result = all ones, hi = a.
REQ-025 DONE: out_valid = 1; result, hi, zero held stable until out_valid && out_ready; then DONE -> IDLE.
REQ-026 No new request accepted in the DONE cycle; back-to-back throughput is one op per 2 cycles minimum.
REQ-027 zero computed from registered result only.

Reset
REQ-028 clrn low: state = IDLE; out_valid = 0; result, hi = 0; zero = 1; in_ready = 1 after release.
REQ-029 Reset during CALC or DONE discards operation; no out_valid afterwards for it.

Structure
REQ-030 Shared package alu_pkg holds aluc code constants and FSM state encoding; reused by the CPU decoder.
REQ-031 Single-cycle datapath in sub-module alu_comb (a, b, aluc -> result); iter_alu holds FSM and MUL/DIV iteration registers.

Verification (WIDTH = 32)
REQ-032 ADD a=127 b=128 -> result 255, zero 0, out_valid 1 cycle after accept.
REQ-033 SUB a=128 b=128 -> result 0, zero 1; SRA a=4 b=0x8000_0000 -> 0xF800_0000.
REQ-034 MULU a=0xFFFF_FFFF b=2 -> result 0xFFFF_FFFE, hi 1, out_valid exactly 33 cycles after accept; in_ready 0 throughout.
REQ-035 DIVU a=100 b=7 -> result 14, hi 2, latency 33; DIVU a=5 b=0 -> result 0xFFFF_FFFF, hi 5, latency 1.
REQ-036 out_ready held low 5 cycles in DONE -> outputs unchanged, in_valid ignored; then handshake -> IDLE next cycle.
REQ-037 clrn pulsed low at cycle 10 of MULU -> out_valid 0, result 0, in_ready 1 after release, next ADD correct.
